// File: rtl/instr_encoder.sv
// Two-stage RV32I instruction assembler: descriptor (class + fields) in, 32-bit word out.
// Optional handshake statistics counters are enabled with INSTR_ENCODER_STATS_EN.
module instr_encoder #(
    parameter logic [31:0] RESET_NOP = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_kind,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err,
    output logic [15:0] cnt_total,
    output logic [15:0] cnt_err
);

    localparam logic [3:0] KIND_R      = 4'd0;
    localparam logic [3:0] KIND_I      = 4'd1;
    localparam logic [3:0] KIND_LOAD   = 4'd2;
    localparam logic [3:0] KIND_STORE  = 4'd3;
    localparam logic [3:0] KIND_BRANCH = 4'd4;
    localparam logic [3:0] KIND_JAL    = 4'd5;
    localparam logic [3:0] KIND_JALR   = 4'd6;
    localparam logic [3:0] KIND_LUI    = 4'd7;
    localparam logic [3:0] KIND_AUIPC  = 4'd8;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic        s1Valid;
    logic [3:0]  s1Kind;
    logic [4:0]  s1Rd;
    logic [4:0]  s1Rs1;
    logic [4:0]  s1Rs2;
    logic [2:0]  s1Funct3;
    logic [6:0]  s1Funct7;
    logic [31:0] s1Imm;

    logic        s2Valid;
    logic [31:0] s2Instr;
    logic        s2Err;

    logic        s2Adv;
    logic        s1Adv;
    logic        accept;

    logic [31:0] encWord;
    logic        encErr;
    logic        fits12;
    logic        fits13;
    logic        fits21;
    logic        isShift;

    assign s2Adv    = !s2Valid || out_ready;
    assign s1Adv    = s1Valid && s2Adv;
    assign in_ready = !s1Valid || s2Adv;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1Valid  <= 1'b0;
            s1Kind   <= 4'd0;
            s1Rd     <= 5'd0;
            s1Rs1    <= 5'd0;
            s1Rs2    <= 5'd0;
            s1Funct3 <= 3'd0;
            s1Funct7 <= 7'd0;
            s1Imm    <= 32'd0;
        end else if (accept) begin
            s1Valid  <= 1'b1;
            s1Kind   <= in_kind;
            s1Rd     <= in_rd;
            s1Rs1    <= in_rs1;
            s1Rs2    <= in_rs2;
            s1Funct3 <= in_funct3;
            s1Funct7 <= in_funct7;
            s1Imm    <= in_imm;
        end else if (s1Adv) begin
            s1Valid  <= 1'b0;
        end
    end

    // Signed range checks: the discarded upper bits must all equal the kept sign bit.
    assign fits12  = (&s1Imm[31:11]) || !(|s1Imm[31:11]);
    assign fits13  = (&s1Imm[31:12]) || !(|s1Imm[31:12]);
    assign fits21  = (&s1Imm[31:20]) || !(|s1Imm[31:20]);
    assign isShift = (s1Funct3 == 3'b001) || (s1Funct3 == 3'b101);

    always_comb begin
        encWord = RESET_NOP;
        encErr  = 1'b1;
        case (s1Kind)
            KIND_R: begin
                encWord = {s1Funct7, s1Rs2, s1Rs1, s1Funct3, s1Rd, OP_R};
                encErr  = 1'b0;
            end
            KIND_I: begin
                if (isShift) begin
                    encWord = {s1Funct7, s1Imm[4:0], s1Rs1, s1Funct3, s1Rd, OP_I};
                    encErr  = |s1Imm[31:5];
                end else begin
                    encWord = {s1Imm[11:0], s1Rs1, s1Funct3, s1Rd, OP_I};
                    encErr  = !fits12;
                end
            end
            KIND_LOAD: begin
                encWord = {s1Imm[11:0], s1Rs1, s1Funct3, s1Rd, OP_LOAD};
                encErr  = !fits12;
            end
            KIND_STORE: begin
                encWord = {s1Imm[11:5], s1Rs2, s1Rs1, s1Funct3, s1Imm[4:0], OP_STORE};
                encErr  = !fits12;
            end
            KIND_BRANCH: begin
                encWord = {s1Imm[12], s1Imm[10:5], s1Rs2, s1Rs1, s1Funct3,
                           s1Imm[4:1], s1Imm[11], OP_BRANCH};
                encErr  = !fits13 || s1Imm[0];
            end
            KIND_JAL: begin
                encWord = {s1Imm[20], s1Imm[10:1], s1Imm[11], s1Imm[19:12], s1Rd, OP_JAL};
                encErr  = !fits21 || s1Imm[0];
            end
            KIND_JALR: begin
                encWord = {s1Imm[11:0], s1Rs1, 3'b000, s1Rd, OP_JALR};
                encErr  = !fits12;
            end
            KIND_LUI: begin
                encWord = {s1Imm[31:12], s1Rd, OP_LUI};
                encErr  = 1'b0;
            end
            KIND_AUIPC: begin
                encWord = {s1Imm[31:12], s1Rd, OP_AUIPC};
                encErr  = 1'b0;
            end
            default: begin
                encWord = RESET_NOP;
                encErr  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2Valid <= 1'b0;
            s2Instr <= 32'd0;
            s2Err   <= 1'b0;
        end else if (s2Adv) begin
            s2Valid <= s1Valid;
            if (s1Valid) begin
                s2Instr <= encWord;
                s2Err   <= encErr;
            end
        end
    end

    assign out_valid = s2Valid;
    assign out_instr = s2Instr;
    assign out_err   = s2Err;

`ifdef INSTR_ENCODER_STATS_EN
    logic [15:0] cntTotalQ;
    logic [15:0] cntErrQ;
    logic        outFire;

    assign outFire = s2Valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cntTotalQ <= 16'd0;
            cntErrQ   <= 16'd0;
        end else if (outFire) begin
            if (cntTotalQ != 16'hFFFF) cntTotalQ <= cntTotalQ + 16'd1;
            if (s2Err && (cntErrQ != 16'hFFFF)) cntErrQ <= cntErrQ + 16'd1;
        end
    end

    assign cnt_total = cntTotalQ;
    assign cnt_err   = cntErrQ;
`else
    assign cnt_total = 16'd0;
    assign cnt_err   = 16'd0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, range errors, backpressure and async reset.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_instr_encoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_kind;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic [15:0] cnt_total;
    logic [15:0] cnt_err;

    int nChecks = 0;
    int nFails  = 0;

    instr_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_kind   (in_kind),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .cnt_total (cnt_total),
        .cnt_err   (cnt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic drive(input logic [3:0] kind, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] imm);
        in_valid  = 1'b1;
        in_kind   = kind;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm    = imm;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One descriptor with out_ready high: presented now, visible two edges later.
    task automatic single(input string tag, input logic [3:0] kind, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] imm,
                          input logic [31:0] expWord, input logic expErr);
        out_ready = 1'b1;
        drive(kind, rd, rs1, rs2, f3, f7, imm);
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        nextCycle();
        in_valid = 1'b0;
        check({tag, "_early_valid"}, {31'd0, out_valid}, 32'd0);
        nextCycle();
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_instr"}, out_instr, expWord);
        check({tag, "_err"}, {31'd0, out_err}, {31'd0, expErr});
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(4'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        in_valid  = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_err", {31'd0, out_err}, 32'd0);
        check("rst_cnt_total", {16'd0, cnt_total}, 32'd0);
        check("rst_cnt_err", {16'd0, cnt_err}, 32'd0);
        #11 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Five words, two of them errors, for the statistics counters.
        single("r_add",   4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0,        32'h002081B3, 1'b0);
        single("i_neg1",  4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 32'hFFF00093, 1'b0);
        single("i_2048",  4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,     32'h80000093, 1'b1);
        single("illegal", 4'd12, 5'd7, 5'd3, 5'd4, 3'd5, 7'd9, 32'd123,     32'h00000013, 1'b1);
        single("store",   4'd3, 5'd0, 5'd2, 5'd5, 3'd3, 7'd0, 32'd8,        32'h00513423, 1'b0);
        nextCycle();
        check("drain_valid", {31'd0, out_valid}, 32'd0);
`ifdef INSTR_ENCODER_STATS_EN
        check("cnt_total_5", {16'd0, cnt_total}, 32'd5);
        check("cnt_err_2", {16'd0, cnt_err}, 32'd2);
`else
        check("cnt_total_off", {16'd0, cnt_total}, 32'd0);
        check("cnt_err_off", {16'd0, cnt_err}, 32'd0);
`endif

        single("jal",     4'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800, 32'h001000EF, 1'b0);
        single("br_odd",  4'd4, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3,        32'h00000163, 1'b1);
        single("beq_m4",  4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC, 32'hFE208EE3, 1'b0);
        single("slli",    4'd1, 5'd1, 5'd2, 5'd0, 3'd1, 7'd0, 32'd3,        32'h00311093, 1'b0);
        single("srai_33", 4'd1, 5'd1, 5'd2, 5'd0, 3'd5, 7'h20, 32'd33,      32'h40115093, 1'b1);
        single("lui",     4'd7, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 1'b0);
        single("jalr",    4'd6, 5'd1, 5'd2, 5'd0, 3'd7, 7'd0, 32'd4,        32'h004100E7, 1'b0);
        nextCycle();

        // Back-to-back stream with a three-cycle consumer stall.
        out_ready = 1'b1;
        drive(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        nextCycle();
        drive(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF);
        check("s_in_ready_1", {31'd0, in_ready}, 32'd1);
        nextCycle();
        check("s_d0_valid", {31'd0, out_valid}, 32'd1);
        check("s_d0_instr", out_instr, 32'h002081B3);
        out_ready = 1'b0;
        drive(4'd3, 5'd0, 5'd2, 5'd5, 3'd3, 7'd0, 32'd8);
        #1;
        check("s_full_in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            check("s_stall_valid", {31'd0, out_valid}, 32'd1);
            check("s_stall_instr", out_instr, 32'h002081B3);
            check("s_stall_err", {31'd0, out_err}, 32'd0);
            check("s_stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("s_release_in_ready", {31'd0, in_ready}, 32'd1);
        nextCycle();
        check("s_d1_instr", out_instr, 32'hFFF00093);
        drive(4'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800);
        nextCycle();
        in_valid = 1'b0;
        check("s_d2_valid", {31'd0, out_valid}, 32'd1);
        check("s_d2_instr", out_instr, 32'h00513423);
        nextCycle();
        check("s_d3_valid", {31'd0, out_valid}, 32'd1);
        check("s_d3_instr", out_instr, 32'h001000EF);
        nextCycle();
        check("s_empty", {31'd0, out_valid}, 32'd0);

        // Fill both stages under backpressure, then reset asynchronously.
        out_ready = 1'b0;
        drive(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        nextCycle();
        drive(4'd7, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
        nextCycle();
        in_valid = 1'b0;
        check("f_valid", {31'd0, out_valid}, 32'd1);
        check("f_in_ready", {31'd0, in_ready}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid", {31'd0, out_valid}, 32'd0);
        check("ar_instr", out_instr, 32'd0);
        check("ar_cnt_total", {16'd0, cnt_total}, 32'd0);
        #7 rst_n = 1'b1;
        #1;
        check("ar_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            check("ar_no_stale", {31'd0, out_valid}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
